// File: rtl/register_file_if.sv
// Register file port bundle: write-back port, two operand read ports, a debug
// read port and the committed-write counter. Parameters must match register_file.
interface register_file_if #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              we_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [N-1:0]      rd_data_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [N-1:0]      rs1_data_o;
    logic [N-1:0]      rs2_data_o;
    logic [N-1:0]      dbg_data_o;
    logic [15:0]       wr_count_o;

    // Datapath side: drives write-back and read addresses, consumes read data
    modport master (
        output we_i, rd_addr_i, rd_data_i, rs1_addr_i, rs2_addr_i, dbg_addr_i,
        input  rs1_data_o, rs2_data_o, dbg_data_o, wr_count_o
    );

    // Register file side
    modport slave (
        input  we_i, rd_addr_i, rd_data_i, rs1_addr_i, rs2_addr_i, dbg_addr_i,
        output rs1_data_o, rs2_data_o, dbg_data_o, wr_count_o
    );
endinterface

// File: rtl/register_file.sv
// Integer register bank: one synchronous write port, three combinational read
// ports (rs1, rs2, debug), register 0 hardwired to zero, saturating write count.
// Optional macro REGFILE_BYPASS_EN: forward the in-flight write-back data to any
// read port addressing the register being written in the same cycle.
module register_file #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned REGS   = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    register_file_if.slave  bus
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     r_regs [REGS];
    logic [CNT_W-1:0] r_wr_count;

    logic             w_wr_valid;
    logic [N-1:0]     w_rs1_data;
    logic [N-1:0]     w_rs2_data;
    logic [N-1:0]     w_dbg_data;

    // Index addresses a real register: not r0 and inside the bank
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < REGS);
    endfunction

    // A write commits only to a live index and never while reset is held
    assign w_wr_valid = bus.we_i && f_live(bus.rd_addr_i) && !rst_i;

    // Register storage; reset clears the whole bank asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[bus.rd_addr_i] <= bus.rd_data_i;
        end
    end

    // Committed-write counter, holds at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_count <= '0;
        end else if (w_wr_valid && (r_wr_count != CNT_MAX)) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    // Operand port 1: stored value, optionally overridden by the in-flight write
    always_comb begin
        w_rs1_data = '0;
        if (f_live(bus.rs1_addr_i)) begin
            w_rs1_data = r_regs[bus.rs1_addr_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (bus.rs1_addr_i == bus.rd_addr_i)) begin
            w_rs1_data = bus.rd_data_i;
        end
`endif
    end

    // Operand port 2
    always_comb begin
        w_rs2_data = '0;
        if (f_live(bus.rs2_addr_i)) begin
            w_rs2_data = r_regs[bus.rs2_addr_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (bus.rs2_addr_i == bus.rd_addr_i)) begin
            w_rs2_data = bus.rd_data_i;
        end
`endif
    end

    // Debug/display port
    always_comb begin
        w_dbg_data = '0;
        if (f_live(bus.dbg_addr_i)) begin
            w_dbg_data = r_regs[bus.dbg_addr_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (bus.dbg_addr_i == bus.rd_addr_i)) begin
            w_dbg_data = bus.rd_data_i;
        end
`endif
    end

    assign bus.rs1_data_o = w_rs1_data;
    assign bus.rs2_data_o = w_rs2_data;
    assign bus.dbg_data_o = w_dbg_data;
    assign bus.wr_count_o = r_wr_count;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected port values,
// a negedge monitor pops and compares them against the DUT.
module tb_register_file;

    localparam int unsigned N      = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned REGS   = 32;

    localparam int K_RS1 = 0;
    localparam int K_RS2 = 1;
    localparam int K_DBG = 2;
    localparam int K_CNT = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;

    register_file_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    register_file #(.N(N), .ADDR_W(ADDR_W), .REGS(REGS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t        q[$];
    string       qn[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_regs [32];
    logic [15:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input int kind, input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = kind;
        x.exp  = e;
        q.push_back(x);
        qn.push_back(nm);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (a != 5'd0) begin
            m_regs[a] = d;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    // Monitor: drain all pending expectations mid-cycle, away from the edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        x;
            string       nm;
            logic [31:0] act;
            x  = q.pop_front();
            nm = qn.pop_front();
            case (x.kind)
                K_RS1:   act = bus.rs1_data_o;
                K_RS2:   act = bus.rs2_data_o;
                K_DBG:   act = bus.dbg_data_o;
                default: act = 32'(bus.wr_count_o);
            endcase
            n_cmp++;
            if (act !== x.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, act, x.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  a;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 16'h0;

        rst            = 1'b1;
        bus.we_i       = 1'b0;
        bus.rd_addr_i  = '0;
        bus.rd_data_i  = '0;
        bus.rs1_addr_i = 5'd5;
        bus.rs2_addr_i = 5'd7;
        bus.dbg_addr_i = 5'd31;
        #1;
        expect_val(K_RS1, 32'h0, "reset_rs1");
        expect_val(K_RS2, 32'h0, "reset_rs2");
        expect_val(K_DBG, 32'h0, "reset_dbg");
        expect_val(K_CNT, 32'h0, "reset_cnt");
        step();
        step();
        rst = 1'b0;

        // Basic write then both sources on the same register
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd5; bus.rd_data_i = 32'hDEADBEEF;
        step();
        model_write(5'd5, 32'hDEADBEEF);
        bus.we_i = 1'b0; bus.rs1_addr_i = 5'd5; bus.rs2_addr_i = 5'd5;
        expect_val(K_RS1, 32'hDEADBEEF, "wr5_rs1");
        expect_val(K_RS2, 32'hDEADBEEF, "wr5_rs2");
        expect_val(K_CNT, 32'd1, "wr5_cnt");

        // Write to r0 is discarded and not counted
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd0; bus.rd_data_i = 32'hFFFFFFFF;
        step();
        bus.we_i = 1'b0; bus.rs1_addr_i = 5'd0;
        expect_val(K_RS1, 32'h0, "r0_rs1");
        expect_val(K_CNT, 32'd1, "r0_cnt");

        // Same-cycle read/write of r7
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd7; bus.rd_data_i = 32'h1;
        step();
        model_write(5'd7, 32'h1);
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd7; bus.rd_data_i = 32'h2; bus.rs1_addr_i = 5'd7;
`ifdef REGFILE_BYPASS_EN
        expect_val(K_RS1, 32'h2, "r7_same_cycle");
`else
        expect_val(K_RS1, 32'h1, "r7_same_cycle");
`endif
        step();
        model_write(5'd7, 32'h2);
        bus.we_i = 1'b0;
        expect_val(K_RS1, 32'h2, "r7_after_edge");
        expect_val(K_CNT, 32'd3, "r7_cnt");

        // Async reset raised between edges clears everything before the next edge
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd9; bus.rd_data_i = 32'h55;
        step();
        bus.we_i = 1'b0;
        bus.rs1_addr_i = 5'd9; bus.rs2_addr_i = 5'd5; bus.dbg_addr_i = 5'd7;
        #2;
        rst = 1'b1;
        #1;
        expect_val(K_RS1, 32'h0, "async_rst_rs1");
        expect_val(K_RS2, 32'h0, "async_rst_rs2");
        expect_val(K_DBG, 32'h0, "async_rst_dbg");
        expect_val(K_CNT, 32'h0, "async_rst_cnt");
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 16'h0;
        step();
        rst = 1'b0;

        // Reset held across an edge with a pending write: write lost
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd3; bus.rd_data_i = 32'hA5A5A5A5;
        rst = 1'b1;
        step();
        rst = 1'b0; bus.we_i = 1'b0; bus.dbg_addr_i = 5'd3;
        expect_val(K_DBG, 32'h0, "rst_mid_write_dbg");
        expect_val(K_CNT, 32'h0, "rst_mid_write_cnt");

        // Normal write after reset release
        bus.we_i = 1'b1; bus.rd_addr_i = 5'd3; bus.rd_data_i = 32'h12345678;
        step();
        model_write(5'd3, 32'h12345678);
        bus.we_i = 1'b0;
        expect_val(K_DBG, 32'h12345678, "post_rst_dbg");
        expect_val(K_CNT, 32'd1, "post_rst_cnt");

        // 65536 valid writes: counter saturates, no wrap
        for (int i = 0; i < 65536; i++) begin
            a = 5'((i % 31) + 1);
            d = {16'(i), ~16'(i)};
            bus.we_i = 1'b1; bus.rd_addr_i = a; bus.rd_data_i = d;
            step();
            model_write(a, d);
            if (i == 0 || i == 65532 || i == 65533 || i == 65535) begin
                expect_val(K_CNT, 32'(m_cnt), "sat_cnt");
            end
        end
        bus.we_i = 1'b0;
        expect_val(K_CNT, 32'h0000FFFF, "sat_final");

        // Debug port sweep against the model
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr_i = 5'(i);
            expect_val(K_DBG, m_regs[i], "dbg_sweep");
            step();
        end

        bus.rs1_addr_i = 5'd17; bus.rs2_addr_i = 5'd17;
        expect_val(K_RS1, m_regs[17], "same_src_rs1");
        expect_val(K_RS2, m_regs[17], "same_src_rs2");
        step();
        step();

        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
